muldiv_reservation_station: RTL and testbench

MULDIV_RESERVATION_STATION -- requirements
Module: muldiv_reservation_station

---
 rtl/muldiv_reservation_station.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_reservation_station.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_reservation_station.sv
// Reservation station for a multiply/divide unit: ENTRIES slots with CDB wakeup and one-at-a-time issue.
// Optional RS_AGE_PRIORITY_EN: issue the oldest READY entry instead of the lowest-index one.
module muldiv_reservation_station #(
  parameter int         ENTRIES  = 3,
  parameter logic [3:0] TAG_BASE = 4'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dispatch_valid,
  input  logic        dispatch_ismul,
  input  logic [31:0] dispatch_Vj,
  input  logic [31:0] dispatch_Vk,
  input  logic [3:0]  dispatch_Qj,
  input  logic [3:0]  dispatch_Qk,
  output logic        rs_full,
  output logic [3:0]  dispatch_tag,
  input  logic        cdb_valid,
  input  logic [3:0]  cdb_tag,
  input  logic [31:0] cdb_data,
  output logic        start,
  output logic [31:0] SrcA,
  output logic [31:0] SrcB,
  output logic [3:0]  Tag_in,
  output logic        ismultiply
);

  typedef enum logic [1:0] {ST_FREE = 2'd0, ST_WAIT = 2'd1, ST_READY = 2'd2, ST_EXEC = 2'd3} ent_state_t;
  typedef enum logic {U_IDLE = 1'b0, U_BUSY = 1'b1} unit_state_t;

  ent_state_t  state_r [ENTRIES];
  logic [31:0] vj_r    [ENTRIES];
  logic [31:0] vk_r    [ENTRIES];
  logic [3:0]  qj_r    [ENTRIES];
  logic [3:0]  qk_r    [ENTRIES];
  logic        op_r    [ENTRIES];
  unit_state_t unit_r;

  logic               free_found_s, ready_found_s;
  logic [1:0]         free_idx_s, ready_idx_s, exec_idx_s;
  logic [ENTRIES-1:0] hit_j_s, hit_k_s;
  logic               dispatch_fire_s, fwd_j_s, fwd_k_s, issue_s, direct_s, done_s;
  logic [31:0]        disp_vj_s, disp_vk_s, iss_vj_s, iss_vk_s;
  logic [3:0]         disp_qj_s, disp_qk_s, iss_tag_s;
  logic               iss_op_s;

  // Lowest free slot, the executing slot, and per-entry CDB tag hits.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = 2'd0;
    exec_idx_s   = 2'd0;
    hit_j_s      = {ENTRIES{1'b0}};
    hit_k_s      = {ENTRIES{1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      free_found_s = free_found_s | (state_r[i] == ST_FREE);
      free_idx_s   = (state_r[i] == ST_FREE) ? 2'(i) : free_idx_s;
      exec_idx_s   = (state_r[i] == ST_EXEC) ? 2'(i) : exec_idx_s;
      hit_j_s[i]   = cdb_valid & (qj_r[i] != 4'd0) & (qj_r[i] == cdb_tag);
      hit_k_s[i]   = cdb_valid & (qk_r[i] != 4'd0) & (qk_r[i] == cdb_tag);
    end
  end

`ifdef RS_AGE_PRIORITY_EN
  // Ages stay distinct in 0..live-1: larger means dispatched earlier.
  logic [1:0] age_r [ENTRIES];
  logic [1:0] best_age_s;

  // Oldest READY entry.
  always_comb begin
    ready_found_s = 1'b0;
    ready_idx_s   = 2'd0;
    best_age_s    = 2'd0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (state_r[i] == ST_READY && (!ready_found_s || age_r[i] > best_age_s)) begin
        ready_found_s = 1'b1;
        ready_idx_s   = 2'(i);
        best_age_s    = age_r[i];
      end else begin
        ready_found_s = ready_found_s;
      end
    end
  end

  // Age bookkeeping: new entries start youngest; entries older than a freed one close the gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) age_r[i] <= 2'd0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (dispatch_fire_s && free_idx_s == 2'(i))
          age_r[i] <= 2'd0;
        else if (state_r[i] != ST_FREE)
          age_r[i] <= age_r[i] + {1'b0, dispatch_fire_s}
                      - {1'b0, (done_s && (age_r[i] > age_r[exec_idx_s]))};
      end
    end
  end
`else
  // Lowest-index READY entry.
  always_comb begin
    ready_found_s = 1'b0;
    ready_idx_s   = 2'd0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      ready_found_s = ready_found_s | (state_r[i] == ST_READY);
      ready_idx_s   = (state_r[i] == ST_READY) ? 2'(i) : ready_idx_s;
    end
  end
`endif

  // Dispatch forwarding and issue selection; a fully ready dispatch into an idle unit bypasses the slot.
  always_comb begin
    dispatch_fire_s = dispatch_valid & free_found_s;
    fwd_j_s   = cdb_valid & (dispatch_Qj != 4'd0) & (dispatch_Qj == cdb_tag);
    fwd_k_s   = cdb_valid & (dispatch_Qk != 4'd0) & (dispatch_Qk == cdb_tag);
    disp_vj_s = fwd_j_s ? cdb_data : dispatch_Vj;
    disp_vk_s = fwd_k_s ? cdb_data : dispatch_Vk;
    disp_qj_s = fwd_j_s ? 4'd0 : dispatch_Qj;
    disp_qk_s = fwd_k_s ? 4'd0 : dispatch_Qk;
    issue_s   = (unit_r == U_IDLE) & ready_found_s;
    direct_s  = (unit_r == U_IDLE) & ~ready_found_s & dispatch_fire_s
                & (dispatch_Qj == 4'd0) & (dispatch_Qk == 4'd0);
    done_s    = (unit_r == U_BUSY) & cdb_valid & (cdb_tag == Tag_in);
    iss_vj_s  = direct_s ? dispatch_Vj : vj_r[ready_idx_s];
    iss_vk_s  = direct_s ? dispatch_Vk : vk_r[ready_idx_s];
    iss_op_s  = direct_s ? dispatch_ismul : op_r[ready_idx_s];
    iss_tag_s = direct_s ? (TAG_BASE + {2'b00, free_idx_s}) : (TAG_BASE + {2'b00, ready_idx_s});
    rs_full      = ~free_found_s;
    dispatch_tag = TAG_BASE + {2'b00, free_idx_s};
  end

  // Entry state machines: dispatch write, CDB wakeup, issue and completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        state_r[i] <= ST_FREE;
        vj_r[i]    <= 32'd0;
        vk_r[i]    <= 32'd0;
        qj_r[i]    <= 4'd0;
        qk_r[i]    <= 4'd0;
        op_r[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (dispatch_fire_s && free_idx_s == 2'(i)) begin
          vj_r[i] <= disp_vj_s;
          vk_r[i] <= disp_vk_s;
          qj_r[i] <= disp_qj_s;
          qk_r[i] <= disp_qk_s;
          op_r[i] <= dispatch_ismul;
          if (direct_s)
            state_r[i] <= ST_EXEC;
          else if (disp_qj_s == 4'd0 && disp_qk_s == 4'd0)
            state_r[i] <= ST_READY;
          else
            state_r[i] <= ST_WAIT;
        end else begin
          case (state_r[i])
            ST_WAIT: begin
              if (hit_j_s[i]) begin
                vj_r[i] <= cdb_data;
                qj_r[i] <= 4'd0;
              end
              if (hit_k_s[i]) begin
                vk_r[i] <= cdb_data;
                qk_r[i] <= 4'd0;
              end
              if ((hit_j_s[i] || qj_r[i] == 4'd0) && (hit_k_s[i] || qk_r[i] == 4'd0))
                state_r[i] <= ST_READY;
            end
            ST_READY: if (issue_s && ready_idx_s == 2'(i)) state_r[i] <= ST_EXEC;
            ST_EXEC:  if (done_s) state_r[i] <= ST_FREE;
            default:  state_r[i] <= ST_FREE;
          endcase
        end
      end
    end
  end

  // Unit FSM with registered issue outputs; Tag_in/ismultiply hold until completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      unit_r     <= U_IDLE;
      start      <= 1'b0;
      SrcA       <= 32'd0;
      SrcB       <= 32'd0;
      Tag_in     <= 4'd0;
      ismultiply <= 1'b0;
    end else begin
      start <= 1'b0;
      case (unit_r)
        U_IDLE: begin
          if (issue_s || direct_s) begin
            unit_r     <= U_BUSY;
            start      <= 1'b1;
            SrcA       <= iss_vj_s;
            SrcB       <= iss_vk_s;
            Tag_in     <= iss_tag_s;
            ismultiply <= iss_op_s;
          end
        end
        U_BUSY:  if (done_s) unit_r <= U_IDLE;
        default: unit_r <= U_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_reservation_station.sv
// Directed self-checking bench for muldiv_reservation_station (default and RS_AGE_PRIORITY_EN builds).
module tb_muldiv_reservation_station;

  logic        clk;
  logic        reset;
  logic        dispatch_valid, dispatch_ismul;
  logic [31:0] dispatch_Vj, dispatch_Vk;
  logic [3:0]  dispatch_Qj, dispatch_Qk;
  logic        rs_full;
  logic [3:0]  dispatch_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        start;
  logic [31:0] SrcA, SrcB;
  logic [3:0]  Tag_in;
  logic        ismultiply;

  int checks   = 0;
  int failures = 0;

  muldiv_reservation_station #(.ENTRIES(3), .TAG_BASE(4'd4)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_ismul(dispatch_ismul),
    .dispatch_Vj(dispatch_Vj), .dispatch_Vk(dispatch_Vk),
    .dispatch_Qj(dispatch_Qj), .dispatch_Qk(dispatch_Qk),
    .rs_full(rs_full), .dispatch_tag(dispatch_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .start(start), .SrcA(SrcA), .SrcB(SrcB), .Tag_in(Tag_in), .ismultiply(ismultiply)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch_set(input logic mul, input logic [31:0] vj, input logic [31:0] vk,
                              input logic [3:0] qj, input logic [3:0] qk);
    dispatch_valid = 1'b1;
    dispatch_ismul = mul;
    dispatch_Vj    = vj;
    dispatch_Vk    = vk;
    dispatch_Qj    = qj;
    dispatch_Qk    = qk;
  endtask

  task automatic cdb_set(input logic [3:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  task automatic clear_inputs();
    dispatch_valid = 1'b0;
    dispatch_ismul = 1'b0;
    dispatch_Vj    = 32'd0;
    dispatch_Vk    = 32'd0;
    dispatch_Qj    = 4'd0;
    dispatch_Qk    = 4'd0;
    cdb_valid      = 1'b0;
    cdb_tag        = 4'd0;
    cdb_data       = 32'd0;
  endtask

  task automatic complete(input logic [3:0] tag);
    cdb_set(tag, 32'h0);
    step();
    clear_inputs();
  endtask

  initial begin
    logic got;
    reset = 1'b0;
    clear_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_start", start, 1'b0);
    check_value("rst_tag_in", Tag_in, 4'd0);
    check_value("rst_srca", SrcA, 32'd0);
    check_value("rst_full", rs_full, 1'b0);
    check_value("rst_dtag", dispatch_tag, 4'd4);
    reset = 1'b1;
    step();

    // Test 1: ready MUL issues in the first cycle after dispatch
    dispatch_set(1'b1, 32'd7, 32'hFFFFFFFD, 4'd0, 4'd0);
    check_value("t1_dtag_pre", dispatch_tag, 4'd4);
    step();
    clear_inputs();
    check_value("t1_start", start, 1'b1);
    check_value("t1_srca", SrcA, 32'd7);
    check_value("t1_srcb", SrcB, 32'hFFFFFFFD);
    check_value("t1_tag_in", Tag_in, 4'd4);
    check_value("t1_ismul", ismultiply, 1'b1);
    check_value("t1_dtag_busy", dispatch_tag, 4'd5);
    step();
    check_value("t1_start_pulse", start, 1'b0);
    complete(4'd4);
    check_value("t1_dtag_free", dispatch_tag, 4'd4);
    check_value("t1_full", rs_full, 1'b0);

    // Test 2: DIV waits on tag 9, wakes via CDB, issues one cycle after becoming READY
    dispatch_set(1'b0, 32'd0, 32'd5, 4'd9, 4'd0);
    step();
    clear_inputs();
    check_value("t2_no_start", start, 1'b0);
    check_value("t2_dtag", dispatch_tag, 4'd5);
    step();
    cdb_set(4'd9, 32'd100);
    step();
    clear_inputs();
    check_value("t2_ready_no_start", start, 1'b0);
    step();
    check_value("t2_start", start, 1'b1);
    check_value("t2_srca", SrcA, 32'd100);
    check_value("t2_srcb", SrcB, 32'd5);
    check_value("t2_tag_in", Tag_in, 4'd4);
    check_value("t2_ismul", ismultiply, 1'b0);
    complete(4'd4);

    // Test 3: fill the station, ignored fourth dispatch, free slot reappears
    dispatch_set(1'b1, 32'h10, 32'h11, 4'd0, 4'd0);
    step();
    dispatch_set(1'b1, 32'h0, 32'h77, 4'd12, 4'd0);
    step();
    dispatch_set(1'b0, 32'h0, 32'h0, 4'd12, 4'd12);
    step();
    check_value("t3_full", rs_full, 1'b1);
    dispatch_set(1'b1, 32'hAA, 32'hBB, 4'd0, 4'd0);
    step();
    clear_inputs();
    check_value("t3_full_after_ignored", rs_full, 1'b1);
    complete(4'd4);
    check_value("t3_not_full", rs_full, 1'b0);
    check_value("t3_dtag", dispatch_tag, 4'd4);
    step();
    check_value("t3_idle_no_start", start, 1'b0);
    cdb_set(4'd12, 32'h1234);
    step();
    clear_inputs();
    step();
    check_value("t3_e1_start", start, 1'b1);
    check_value("t3_e1_tag_in", Tag_in, 4'd5);
    check_value("t3_e1_srca", SrcA, 32'h1234);
    check_value("t3_e1_srcb", SrcB, 32'h77);
    complete(4'd5);
    step();
    check_value("t3_e2_start", start, 1'b1);
    check_value("t3_e2_tag_in", Tag_in, 4'd6);
    check_value("t3_e2_srca", SrcA, 32'h1234);
    check_value("t3_e2_srcb", SrcB, 32'h1234);
    complete(4'd6);

    // Test 4: Qk forwarded from the CDB in the dispatch cycle
    dispatch_set(1'b1, 32'd3, 32'd0, 4'd0, 4'd9);
    cdb_set(4'd9, 32'h55);
    step();
    clear_inputs();
    got = (start === 1'b1);
    for (int n = 0; n < 2; n++) begin
      if (!got) begin
        step();
        got = (start === 1'b1);
      end
    end
    check_value("t4_start", got, 1'b1);
    check_value("t4_srcb", SrcB, 32'h55);
    check_value("t4_srca", SrcA, 32'd3);
    check_value("t4_tag_in", Tag_in, 4'd4);
    complete(4'd4);

    // Test 5: busy unit holds a READY entry until completion; foreign tags ignored
    dispatch_set(1'b1, 32'd1, 32'd2, 4'd0, 4'd0);
    step();
    check_value("t5_a_start", start, 1'b1);
    dispatch_set(1'b0, 32'd8, 32'd9, 4'd0, 4'd0);
    step();
    clear_inputs();
    for (int n = 0; n < 3; n++) begin
      cdb_set(4'd9, 32'hDEAD);
      step();
      check_value("t5_hold_start", start, 1'b0);
      check_value("t5_hold_tag_in", Tag_in, 4'd4);
      check_value("t5_hold_ismul", ismultiply, 1'b1);
    end
    complete(4'd4);
    check_value("t5_done_edge_start", start, 1'b0);
    check_value("t5_done_edge_tag_in", Tag_in, 4'd4);
    step();
    check_value("t5_b_start", start, 1'b1);
    check_value("t5_b_tag_in", Tag_in, 4'd5);
    check_value("t5_b_ismul", ismultiply, 1'b0);
    check_value("t5_b_srca", SrcA, 32'd8);
    complete(4'd5);

    // Test 6: asynchronous reset while busy, then issue ordering
    dispatch_set(1'b1, 32'd4, 32'd4, 4'd0, 4'd0);
    step();
    clear_inputs();
    check_value("t6_start", start, 1'b1);
    step();
    check_value("t6_dtag_busy", dispatch_tag, 4'd5);
    reset = 1'b0;
    #1;
    check_value("t6_rst_start", start, 1'b0);
    check_value("t6_rst_tag_in", Tag_in, 4'd0);
    check_value("t6_rst_ismul", ismultiply, 1'b0);
    check_value("t6_rst_full", rs_full, 1'b0);
    check_value("t6_rst_dtag", dispatch_tag, 4'd4);
    step();
    reset = 1'b1;
    step();
    dispatch_set(1'b1, 32'd1, 32'd1, 4'd0, 4'd0);
    step();
    check_value("t6_a_start", start, 1'b1);
    check_value("t6_a_tag_in", Tag_in, 4'd4);
    dispatch_set(1'b0, 32'd0, 32'h11, 4'd10, 4'd0);
    step();
    dispatch_set(1'b0, 32'd0, 32'h22, 4'd11, 4'd0);
    step();
    clear_inputs();
    complete(4'd4);
    check_value("t6_dtag_reuse", dispatch_tag, 4'd4);
    dispatch_set(1'b1, 32'd0, 32'h44, 4'd11, 4'd0);
    step();
    clear_inputs();
    cdb_set(4'd11, 32'h99);
    step();
    clear_inputs();
    check_value("t6_wake_no_start", start, 1'b0);
    step();
    check_value("t6_order_start", start, 1'b1);
`ifdef RS_AGE_PRIORITY_EN
    check_value("t6_order_tag_in", Tag_in, 4'd6);
    check_value("t6_order_srcb", SrcB, 32'h22);
`else
    check_value("t6_order_tag_in", Tag_in, 4'd4);
    check_value("t6_order_srcb", SrcB, 32'h44);
`endif
    check_value("t6_order_srca", SrcA, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
